// File: rtl/sar_scan_ctrl_if.sv
// Bundle between the SAR scan controller and its neighbours: register-file
// config/FIFO/IRQ side plus the analog front-end DAC/comparator/S&H side.
interface sar_scan_ctrl_if #(
  parameter int ADC_WIDTH  = 12,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                      enable;
  logic                      start;
  logic                      continuous;
  logic [NUM_CH-1:0]         ch_mask;
  logic [1:0]                avg_log2;
  logic                      comparator;
  logic [ADC_WIDTH-1:0]      dac;
  logic                      sample_and_hold;
  logic                      dac_rst;
  logic                      pwr_gate;
  logic                      vref_sel;
  logic [CH_W-1:0]           ch_sel;
  logic                      busy;
  logic                      fifo_rd;
  logic [CH_W+ADC_WIDTH-1:0] fifo_data;
  logic                      fifo_empty;
  logic [LVL_W-1:0]          fifo_level;
  logic                      overflow;
  logic [LVL_W-1:0]          irq_thresh;
  logic                      irq_clr;
  logic                      irq;

  modport master (
    output enable, start, continuous, ch_mask, avg_log2, comparator,
           fifo_rd, irq_thresh, irq_clr,
    input  dac, sample_and_hold, dac_rst, pwr_gate, vref_sel, ch_sel, busy,
           fifo_data, fifo_empty, fifo_level, overflow, irq
  );

  modport slave (
    input  enable, start, continuous, ch_mask, avg_log2, comparator,
           fifo_rd, irq_thresh, irq_clr,
    output dac, sample_and_hold, dac_rst, pwr_gate, vref_sel, ch_sel, busy,
           fifo_data, fifo_empty, fifo_level, overflow, irq
  );
endinterface

// File: rtl/sar_scan_ctrl.sv
// Multi-channel SAR scan controller: walks a channel mask, converts and
// averages each channel, and queues {channel, result} words in an FWFT FIFO.
module sar_scan_ctrl #(
  parameter int ADC_WIDTH    = 12,
  parameter int NUM_CH       = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLK_DIV      = 6250,
  parameter int SAMPLE_TICKS = 2,
  parameter int PWRUP_TICKS  = 4
) (
  input logic            sys_clk,
  input logic            reset_,
  sar_scan_ctrl_if.slave scan
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = AW + 1;
  localparam int ACC_W  = ADC_WIDTH + 3;
  localparam int WORD_W = CH_W + ADC_WIDTH;
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int TC_MAX = (PWRUP_TICKS > SAMPLE_TICKS) ? PWRUP_TICKS : SAMPLE_TICKS;
  localparam int TC_W   = $clog2(TC_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PWRUP, S_SAMPLE, S_CONVERT, S_ACCUM, S_STORE
  } state_t;

  function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    lowest_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) lowest_ch = CH_W'(i);
  endfunction

  // Returns {found, channel} for the next set mask bit above cur.
  function automatic logic [CH_W:0] next_ch(input logic [NUM_CH-1:0] m,
                                            input logic [CH_W-1:0]   cur);
    next_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && (i > int'(cur))) next_ch = {1'b1, CH_W'(i)};
  endfunction

  function automatic logic [ADC_WIDTH-1:0] avg_shift(input logic [ACC_W-1:0] acc,
                                                     input logic [1:0]       sh);
    logic [ACC_W-1:0] t;
    t = acc >> sh;
    return t[ADC_WIDTH-1:0];
  endfunction

  state_t               r_state, w_state_nxt;
  logic [DIV_W-1:0]     r_div;
  logic [TC_W-1:0]      r_tcnt;
  logic [ADC_WIDTH-1:0] r_dac, r_trial;
  logic [ACC_W-1:0]     r_acc;
  logic [2:0]           r_scnt;
  logic [CH_W-1:0]      r_ch;
  logic [NUM_CH-1:0]    r_mask;
  logic                 r_cont;
  logic [1:0]           r_avg;
  logic                 w_tick, w_store, w_done, w_sh, w_pwr;
  logic [2:0]           w_scnt_last;
  logic [CH_W:0]        w_nxt;

  logic [WORD_W-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wp, r_rp;
  logic [LVL_W-1:0]     r_lvl;
  logic                 r_ovf, r_irq;
  logic                 w_rd, w_wr, w_drop, w_full, w_lvl_hit;
  logic [WORD_W-1:0]    w_word;

  assign w_tick      = (r_state != S_IDLE) && (r_div == DIV_W'(CLK_DIV - 1));
  assign w_scnt_last = ~(3'b111 << r_avg);
  assign w_nxt       = next_ch(r_mask, r_ch);
  assign w_word      = {r_ch, avg_shift(r_acc, r_avg)};

  always_ff @(posedge sys_clk) begin
    if (reset_) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_done      = 1'b0;
    w_sh        = (r_state == S_SAMPLE);
    w_pwr       = (r_state != S_IDLE);
    if (!scan.enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (scan.start && (|scan.ch_mask)) w_state_nxt = S_PWRUP;
        S_PWRUP:   if (w_tick && r_tcnt == TC_W'(PWRUP_TICKS - 1)) w_state_nxt = S_SAMPLE;
        S_SAMPLE:  if (w_tick && r_tcnt == TC_W'(SAMPLE_TICKS - 1)) w_state_nxt = S_CONVERT;
        S_CONVERT: if (w_tick && r_trial[0]) w_state_nxt = S_ACCUM;
        S_ACCUM:   w_state_nxt = (r_scnt == w_scnt_last) ? S_STORE : S_SAMPLE;
        S_STORE: begin
          w_store = 1'b1;
          if (w_nxt[CH_W] || r_cont) begin
            w_state_nxt = S_SAMPLE;
          end else begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
          end
        end
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: an abort or reset wipes every partial result.
  always_ff @(posedge sys_clk) begin
    if (reset_ || !scan.enable) begin
      r_div <= '0; r_tcnt <= '0; r_dac <= '0; r_trial <= '0; r_acc <= '0;
      r_scnt <= '0; r_ch <= '0; r_mask <= '0; r_cont <= 1'b0; r_avg <= '0;
    end else begin
      r_div <= (r_state == S_IDLE || w_tick) ? '0 : r_div + 1'b1;
      case (r_state)
        S_IDLE: if (scan.start && (|scan.ch_mask)) begin
          r_ch   <= lowest_ch(scan.ch_mask);
          r_mask <= scan.ch_mask;
          r_cont <= scan.continuous;
          r_avg  <= scan.avg_log2;
          r_tcnt <= '0;
          r_acc  <= '0;
          r_scnt <= '0;
        end
        S_PWRUP: if (w_tick)
          r_tcnt <= (r_tcnt == TC_W'(PWRUP_TICKS - 1)) ? '0 : r_tcnt + 1'b1;
        S_SAMPLE: if (w_tick) begin
          if (r_tcnt == TC_W'(SAMPLE_TICKS - 1)) begin
            r_tcnt  <= '0;
            r_dac   <= {1'b1, {(ADC_WIDTH-1){1'b0}}};
            r_trial <= {1'b1, {(ADC_WIDTH-1){1'b0}}};
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_CONVERT: if (w_tick) begin
          r_dac   <= (r_dac & ~r_trial) | (scan.comparator ? r_trial : '0) | (r_trial >> 1);
          r_trial <= r_trial >> 1;
        end
        S_ACCUM: begin
          r_acc  <= r_acc + ACC_W'(r_dac);
          r_dac  <= '0;
          r_scnt <= (r_scnt == w_scnt_last) ? '0 : r_scnt + 1'b1;
        end
        S_STORE: begin
          r_acc <= '0;
          r_ch  <= w_nxt[CH_W] ? w_nxt[CH_W-1:0] : lowest_ch(r_mask);
        end
        default: ;
      endcase
    end
  end

  // Result FIFO: a pop frees the slot for a same-cycle push when full.
  assign w_full    = (r_lvl == LVL_W'(FIFO_DEPTH));
  assign w_rd      = scan.fifo_rd && (r_lvl != '0);
  assign w_wr      = w_store && (!w_full || w_rd);
  assign w_drop    = w_store && !w_wr;
  assign w_lvl_hit = (scan.irq_thresh != '0) && (r_lvl >= scan.irq_thresh);

  always_ff @(posedge sys_clk) begin
    if (w_wr) r_mem[r_wp] <= w_word;
  end

  always_ff @(posedge sys_clk) begin
    if (reset_) begin
      r_wp <= '0; r_rp <= '0; r_lvl <= '0; r_ovf <= 1'b0; r_irq <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_lvl <= r_lvl + 1'b1;
        2'b01:   r_lvl <= r_lvl - 1'b1;
        default: r_lvl <= r_lvl;
      endcase
      r_ovf <= w_drop ? 1'b1 : (scan.irq_clr ? 1'b0 : r_ovf);
      r_irq <= (w_lvl_hit || w_done || (w_drop && !r_ovf)) ? 1'b1 :
               (scan.irq_clr ? 1'b0 : r_irq);
    end
  end

  assign scan.dac             = r_dac;
  assign scan.sample_and_hold = w_sh;
  assign scan.dac_rst         = w_sh;
  assign scan.pwr_gate        = w_pwr;
  assign scan.vref_sel        = 1'b0;
  assign scan.ch_sel          = r_ch;
  assign scan.busy            = (r_state != S_IDLE);
  assign scan.fifo_empty      = (r_lvl == '0);
  assign scan.fifo_data       = (r_lvl == '0) ? '0 : r_mem[r_rp];
  assign scan.fifo_level      = r_lvl;
  assign scan.overflow        = r_ovf;
  assign scan.irq             = r_irq;
endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Directed bench for sar_scan_ctrl with an ideal comparator model per channel.
module tb_sar_scan_ctrl;
  localparam int AWID = 12, NCH = 4, FD = 8, CD = 4, ST = 2, PT = 4;

  logic sys_clk = 1'b0;
  logic reset_;
  always #5 sys_clk = ~sys_clk;

  sar_scan_ctrl_if #(.ADC_WIDTH(AWID), .NUM_CH(NCH), .FIFO_DEPTH(FD)) scan_if ();

  sar_scan_ctrl #(
    .ADC_WIDTH(AWID), .NUM_CH(NCH), .FIFO_DEPTH(FD),
    .CLK_DIV(CD), .SAMPLE_TICKS(ST), .PWRUP_TICKS(PT)
  ) dut (
    .sys_clk(sys_clk),
    .reset_ (reset_),
    .scan   (scan_if.slave)
  );

  logic [11:0] vin [NCH];
  assign scan_if.comparator = (vin[scan_if.ch_sel] >= scan_if.dac);

  int n_checks = 0;
  int n_fail   = 0;
  int cycles, rises;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic start_scan(input logic [3:0] mask, input logic cont, input logic [1:0] avg);
    scan_if.ch_mask    = mask;
    scan_if.continuous = cont;
    scan_if.avg_log2   = avg;
    scan_if.start      = 1'b1;
    cyc(1);
    scan_if.start      = 1'b0;
  endtask

  task automatic wait_idle(input int lim, output int n, output int sh_rises);
    logic prev_sh;
    n = 0; sh_rises = 0;
    prev_sh = scan_if.sample_and_hold;
    while (scan_if.busy && n < lim) begin
      cyc(1);
      n++;
      if (scan_if.sample_and_hold && !prev_sh) sh_rises++;
      prev_sh = scan_if.sample_and_hold;
    end
  endtask

  task automatic wait_level(input int lvl, input int lim, input string tag);
    int n = 0;
    while (scan_if.fifo_level != lvl && n < lim) begin cyc(1); n++; end
    check_val(tag, 32'(scan_if.fifo_level), lvl);
  endtask

  task automatic wait_convert(input int lim, input string tag);
    int n = 0;
    while (scan_if.dac == '0 && n < lim) begin cyc(1); n++; end
    check_val(tag, 32'(scan_if.dac != '0), 1);
  endtask

  task automatic pulse(input int which);
    if (which == 0) scan_if.fifo_rd = 1'b1; else scan_if.irq_clr = 1'b1;
    cyc(1);
    scan_if.fifo_rd = 1'b0;
    scan_if.irq_clr = 1'b0;
  endtask

  initial begin
    logic [11:0] prev_dac;
    int n;
    reset_ = 1'b1;
    scan_if.enable = 1'b1; scan_if.start = 1'b0; scan_if.continuous = 1'b0;
    scan_if.ch_mask = '0; scan_if.avg_log2 = '0; scan_if.fifo_rd = 1'b0;
    scan_if.irq_thresh = '0; scan_if.irq_clr = 1'b0;
    for (int i = 0; i < NCH; i++) vin[i] = '0;
    cyc(3);
    check_val("rst_busy",  32'(scan_if.busy), 0);
    check_val("rst_pwr",   32'(scan_if.pwr_gate), 0);
    check_val("rst_dac",   32'(scan_if.dac), 0);
    check_val("rst_sh",    32'(scan_if.sample_and_hold), 0);
    check_val("rst_empty", 32'(scan_if.fifo_empty), 1);
    check_val("rst_irq",   32'(scan_if.irq), 0);
    reset_ = 1'b0;
    cyc(1);

    // single channel, no averaging
    vin[0] = 12'hA52;
    start_scan(4'b0001, 1'b0, 2'd0);
    wait_idle(1000, cycles, rises);
    check_val("t1_latency", cycles, 18 * CD + 2);
    check_val("t1_level",   32'(scan_if.fifo_level), 1);
    check_val("t1_word",    32'(scan_if.fifo_data), 32'h0A52);
    check_val("t1_done_irq", 32'(scan_if.irq), 1);
    check_val("t1_pwr_off", 32'(scan_if.pwr_gate), 0);
    pulse(0);
    check_val("t1_empty", 32'(scan_if.fifo_empty), 1);
    pulse(1);
    check_val("t1_irq_clr", 32'(scan_if.irq), 0);

    // two channels, 4x averaging
    vin[1] = 12'h123; vin[3] = 12'hFFF;
    start_scan(4'b1010, 1'b0, 2'd2);
    wait_idle(3000, cycles, rises);
    check_val("t2_idle",  32'(scan_if.busy), 0);
    check_val("t2_sh",    rises, 8);
    check_val("t2_level", 32'(scan_if.fifo_level), 2);
    check_val("t2_word0", 32'(scan_if.fifo_data), 32'h1123);
    pulse(0);
    check_val("t2_word1", 32'(scan_if.fifo_data), 32'h3FFF);
    pulse(0);
    check_val("t2_empty", 32'(scan_if.fifo_empty), 1);
    pulse(1);

    // level threshold interrupt
    vin[0] = 12'h055;
    scan_if.irq_thresh = 4'd2;
    start_scan(4'b0001, 1'b1, 2'd0);
    wait_level(1, 1000, "t4_lvl1");
    cyc(2);
    check_val("t4_irq_below", 32'(scan_if.irq), 0);
    wait_level(2, 1000, "t4_lvl2");
    cyc(2);
    check_val("t4_irq_hit", 32'(scan_if.irq), 1);
    pulse(1);
    check_val("t4_irq_reset", 32'(scan_if.irq), 1);
    scan_if.enable = 1'b0;
    cyc(1);
    scan_if.enable = 1'b1;
    scan_if.irq_thresh = '0;
    pulse(0); pulse(0);
    check_val("t4_drained", 32'(scan_if.fifo_empty), 1);
    pulse(1);
    check_val("t4_irq_clr", 32'(scan_if.irq), 0);

    // abort mid-conversion
    vin[0] = 12'h3C3;
    start_scan(4'b0001, 1'b0, 2'd0);
    wait_convert(1000, "t5_in_convert");
    cyc(5);
    scan_if.enable = 1'b0;
    cyc(1);
    check_val("t5_busy", 32'(scan_if.busy), 0);
    check_val("t5_pwr",  32'(scan_if.pwr_gate), 0);
    check_val("t5_dac",  32'(scan_if.dac), 0);
    check_val("t5_level", 32'(scan_if.fifo_level), 0);
    scan_if.enable = 1'b1;
    cyc(20 * CD);
    check_val("t5_no_word", 32'(scan_if.fifo_level), 0);
    check_val("t5_no_irq",  32'(scan_if.irq), 0);

    // ignored starts
    start_scan(4'b0000, 1'b0, 2'd0);
    cyc(1);
    check_val("t6_mask0", 32'(scan_if.busy), 0);
    vin[0] = 12'h111; vin[1] = 12'h222;
    start_scan(4'b0001, 1'b0, 2'd0);
    wait_convert(1000, "t6_in_convert");
    start_scan(4'b0010, 1'b0, 2'd0);
    wait_idle(1000, cycles, rises);
    check_val("t6_level", 32'(scan_if.fifo_level), 1);
    check_val("t6_word",  32'(scan_if.fifo_data), 32'h0111);
    pulse(0);
    pulse(1);

    // continuous without reads: saturation and overflow
    vin[0] = 12'h0AB;
    start_scan(4'b0001, 1'b1, 2'd0);
    wait_level(1, 1000, "t3_lvl1");
    vin[0] = 12'h0CD;
    wait_level(8, 2000, "t3_lvl8");
    check_val("t3_no_ovf_yet", 32'(scan_if.overflow), 0);
    n = 0;
    while (!scan_if.overflow && n < 500) begin cyc(1); n++; end
    check_val("t3_ovf",   32'(scan_if.overflow), 1);
    check_val("t3_irq",   32'(scan_if.irq), 1);
    check_val("t3_level", 32'(scan_if.fifo_level), 8);
    check_val("t3_head",  32'(scan_if.fifo_data), 32'h00AB);
    pulse(1);
    check_val("t3_ovf_clr", 32'(scan_if.overflow), 0);
    check_val("t3_irq_clr", 32'(scan_if.irq), 0);

    // pop in the same cycle as a store into a full FIFO
    n = 0;
    prev_dac = scan_if.dac;
    cyc(1);
    while (!(scan_if.dac == '0 && prev_dac != '0) && n < 500) begin
      prev_dac = scan_if.dac;
      cyc(1);
      n++;
    end
    check_val("t6_store_seen", 32'(n < 500), 1);
    pulse(0);
    check_val("t6_full_level", 32'(scan_if.fifo_level), 8);
    check_val("t6_full_ovf",   32'(scan_if.overflow), 0);
    check_val("t6_full_head",  32'(scan_if.fifo_data), 32'h00CD);
    scan_if.enable = 1'b0;
    cyc(2);
    check_val("t5_fifo_kept", 32'(scan_if.fifo_level), 8);
    scan_if.enable = 1'b1;

    // reset during conversion clears everything, FIFO included
    start_scan(4'b0001, 1'b0, 2'd0);
    wait_convert(1000, "t7_in_convert");
    reset_ = 1'b1;
    cyc(1);
    reset_ = 1'b0;
    check_val("t7_level", 32'(scan_if.fifo_level), 0);
    check_val("t7_empty", 32'(scan_if.fifo_empty), 1);
    check_val("t7_busy",  32'(scan_if.busy), 0);
    check_val("t7_dac",   32'(scan_if.dac), 0);
    check_val("t7_irq",   32'(scan_if.irq), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
